// File: rtl/lsu_pkg.sv
// LSU shared definitions: op encoding, FSM states, error codes.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  localparam int TIMEOUT_DEF = 255;

  function automatic logic misaligned(
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: m = off[0];
      OP_LW, OP_SW:         m = |off;
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// LSU lane steering: store byte enables/replication, load extract/extend.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        we,
  output logic [31:0] wlane,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ldata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    be    = 4'b1111;
    we    = 1'b0;
    wlane = wdata;
    case (st_op)
      OP_SB: begin
        be    = 4'b0001 << st_off;
        we    = 1'b1;
        wlane = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be    = 4'b0011 << st_off;
        we    = 1'b1;
        wlane = {2{wdata[15:0]}};
      end
      OP_SW:   we = 1'b1;
      default: ;
    endcase
  end

  assign b = mem_rdata[{ld_off, 3'b000} +: 8];
  assign h = mem_rdata[{ld_off[1], 4'b0000} +: 16];

  // Stores fall through to zero so rdata reads 0 on completion.
  always_comb begin
    ldata = 32'h0;
    case (ld_op)
      OP_LB:   ldata = {{24{b[7]}}, b};
      OP_LBU:  ldata = {24'h0, b};
      OP_LH:   ldata = {{16{h[15]}}, h};
      OP_LHU:  ldata = {16'h0, h};
      OP_LW:   ldata = mem_rdata;
      default: ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/WAIT/RESP handshake to a word memory port.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_e        state;
  logic [2:0]    op_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;

  logic [3:0]  f_be;
  logic        f_we;
  logic [31:0] f_wlane;
  logic [31:0] f_ldata;

  lsu_fmt u_fmt (
    .st_op     (op),
    .st_off    (addr[1:0]),
    .wdata     (wdata),
    .be        (f_be),
    .we        (f_we),
    .wlane     (f_wlane),
    .ld_op     (op_q),
    .ld_off    (off_q),
    .mem_rdata (mem_rdata),
    .ldata     (f_ldata)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= 3'd0;
      off_q     <= 2'd0;
      cnt       <= '0;
      done      <= 1'b0;
      rdata     <= 32'h0;
      err       <= ERR_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (misaligned(op, addr[1:0])) begin
              state <= ST_RESP;
              done  <= 1'b1;
              err   <= ERR_MIS;
              rdata <= 32'h0;
            end else begin
              state     <= ST_WAIT;
              op_q      <= op;
              off_q     <= addr[1:0];
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= f_we;
              mem_be    <= f_be;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= f_wlane;
            end
          end
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (mem_ack) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= ERR_OK;
            rdata   <= f_ldata;
          end else if (cnt == LAST) begin
            state   <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= ERR_TO;
            rdata   <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, timeout, reset, random.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ack;
  logic        ack4;
  logic [31:0] mem_rdata;

  logic        busy, done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  err;
  logic [3:0]  mem_be;

  logic        busy4, done4, req4, we4;
  logic [31:0] rdata4, addr4, wdata4;
  logic [1:0]  err4;
  logic [3:0]  be4;

  int checks = 0;
  int errors = 0;

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy4), .done(done4), .rdata(rdata4), .err(err4),
    .mem_req(req4), .mem_we(we4), .mem_be(be4),
    .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_ack(ack4), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          dly;
    logic [31:0] rd;
    logic [1:0]  er;
    logic [3:0]  be;
    logic [31:0] mw;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: derive expectations from access size and byte offset.
  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] w, input logic [31:0] m,
                              input int d);
    vec_t v;
    int off, sz, b, h;
    off = int'(a % 32'd4);
    if (o == OP_LW || o == OP_SW) sz = 4;
    else if (o == OP_LH || o == OP_LHU || o == OP_SH) sz = 2;
    else sz = 1;
    b = int'((m >> (8 * off)) & 32'hFF);
    h = int'((m >> (8 * (off - off % 2))) & 32'hFFFF);
    v.op = o; v.addr = a; v.wdata = w; v.mrd = m; v.dly = d;
    v.er = (a % sz != 0) ? ERR_MIS : ERR_OK;
    v.be = (o >= OP_SB && sz < 4) ? 4'(((1 << sz) - 1) << off) : 4'hF;
    case (o)
      OP_SB:   v.mw = (w & 32'hFF) * 32'h01010101;
      OP_SH:   v.mw = (w & 32'hFFFF) * 32'h00010001;
      default: v.mw = w;
    endcase
    case (o)
      OP_LB:   v.rd = 32'(b >= 128 ? b - 256 : b);
      OP_LBU:  v.rd = 32'(b);
      OP_LH:   v.rd = 32'(h >= 32768 ? h - 65536 : h);
      OP_LHU:  v.rd = 32'(h);
      OP_LW:   v.rd = m;
      default: v.rd = 32'h0;
    endcase
    if (v.er != ERR_OK) v.rd = 32'h0;
    return v;
  endfunction

  // Called just after a negedge; start is sampled at the next posedge.
  task automatic run(input vec_t v);
    logic [31:0] ea;
    bit          stable;
    ea = {v.addr[31:2], 2'b00};
    op = v.op; addr = v.addr; wdata = v.wdata; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    addr = $urandom; wdata = $urandom;
    if (v.er == ERR_MIS) begin
      chk("mis_req", mem_req, 0);
      chk("mis_done", done, 1);
      chk("mis_err", err, ERR_MIS);
      chk("mis_rdata", rdata, 0);
      @(negedge clk);
      chk("mis_done_clr", done, 0);
    end else begin
      chk("req", mem_req, 1);
      chk("addr", mem_addr, ea);
      chk("be", mem_be, v.be);
      chk("we", mem_we, v.op >= OP_SB);
      if (v.op >= OP_SB) chk("mwdata", mem_wdata, v.mw);
      chk("busy", busy, 1);
      stable = 1'b1;
      for (int i = 0; i < v.dly; i++) begin
        start = 1'b1;
        @(negedge clk);
        if (mem_req !== 1'b1 || mem_addr !== ea || mem_be !== v.be ||
            done !== 1'b0)
          stable = 1'b0;
      end
      chk("req_stable", 32'(stable), 1);
      start = 1'b0;
      mem_ack = 1'b1; mem_rdata = v.mrd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk("done", done, 1);
      chk("rdata", rdata, v.rd);
      chk("err", err, ERR_OK);
      chk("req_drop", mem_req, 0);
      @(negedge clk);
      chk("done_clr", done, 0);
      chk("idle", busy, 0);
    end
  endtask

  vec_t tbl[11];

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; ack4 = 1'b0; mem_rdata = 32'h0;

    tbl[0]  = '{OP_LW,  32'h10, 32'h0, 32'h8899AABB, 1,
                32'h8899AABB, ERR_OK, 4'hF, 32'h0};
    tbl[1]  = '{OP_LB,  32'h13, 32'h0, 32'h80000000, 0,
                32'hFFFFFF80, ERR_OK, 4'hF, 32'h0};
    tbl[2]  = '{OP_LBU, 32'h13, 32'h0, 32'h80000000, 0,
                32'h00000080, ERR_OK, 4'hF, 32'h0};
    tbl[3]  = '{OP_SH,  32'h22, 32'h1234, 32'h0, 5,
                32'h0, ERR_OK, 4'b1100, 32'h12341234};
    tbl[4]  = '{OP_LW,  32'h6, 32'h0, 32'h0, 0,
                32'h0, ERR_MIS, 4'hF, 32'h0};
    tbl[5]  = '{OP_SB,  32'h01, 32'hAB, 32'h0, 1,
                32'h0, ERR_OK, 4'b0010, 32'hABABABAB};
    tbl[6]  = '{OP_LH,  32'h2, 32'h0, 32'h80011234, 2,
                32'hFFFF8001, ERR_OK, 4'hF, 32'h0};
    tbl[7]  = '{OP_LHU, 32'h2, 32'h0, 32'h80011234, 0,
                32'h00008001, ERR_OK, 4'hF, 32'h0};
    tbl[8]  = '{OP_SW,  32'h4, 32'hDEADBEEF, 32'h0, 0,
                32'h0, ERR_OK, 4'hF, 32'hDEADBEEF};
    tbl[9]  = '{OP_SH,  32'h1, 32'h5555, 32'h0, 0,
                32'h0, ERR_MIS, 4'hF, 32'h0};
    tbl[10] = '{OP_LB,  32'h0, 32'h0, 32'h0000007F, 0,
                32'h0000007F, ERR_OK, 4'hF, 32'h0};

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_we", mem_we, 0);
    chk("rst4", {busy4, done4, req4, we4, be4, err4}, 0);
    chk("rst4_data", rdata4 | addr4 | wdata4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // mem_ack outside WAIT must not complete anything
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ack_idle_done", done, 0);
    chk("ack_idle_busy", busy, 0);

    // Timeout on the TIMEOUT=4 instance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op = OP_LW; addr = 32'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", req4, 1);
      chk("to_nodone", done4, 0);
      @(negedge clk);
    end
    chk("to_done", done4, 1);
    chk("to_err", err4, ERR_TO);
    chk("to_rdata", rdata4, 0);
    chk("to_req_drop", req4, 0);
    @(negedge clk);
    chk("to_done_clr", done4, 0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("drain_done", done, 1);
    @(negedge clk);

    // Reset mid-WAIT, between clock edges
    op = OP_LW; addr = 32'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_req_pre", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_req", mem_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_be", mem_be, 0);
    @(negedge clk);
    rst = 1'b0;
    run(mk(OP_LW, 32'h84, 32'h0, 32'h11223344, 1));

    // Randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      run(mk(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4))));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
